// File: rtl/sprite_motion_ctrl.sv
// Motion scheduler and scan-address generator for one bouncing sprite on the 640x480 path.
// Position updates only after frame end, so the visible image never tears.
module sprite_motion_ctrl #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned SPR_W = 128,
  parameter int unsigned SPR_H = 128,
  parameter int unsigned STEP  = 1,
  parameter int unsigned X0    = 430,
  parameter int unsigned Y0    = 50
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  speed,
  output logic [9:0]  spr_x,
  output logic [9:0]  spr_y,
  output logic        in_sprite,
  output logic [13:0] rom_addr,
  output logic        bounce_x,
  output logic        bounce_y
);

  localparam logic [10:0] XMax    = 11'(H_RES - SPR_W);
  localparam logic [10:0] YMax    = 11'(V_RES - SPR_H);
  localparam logic [10:0] StepW   = 11'(STEP);
  localparam logic [10:0] SprW11  = 11'(SPR_W);
  localparam logic [10:0] SprH11  = 11'(SPR_H);
  localparam logic [9:0]  LastLine = 10'(V_RES - 1);

  typedef enum logic [1:0] {StWait, StCalcX, StCalcY, StCommit} state_e;

  state_e      state_q;
  logic        valid_q;
  logic [3:0]  frame_div_q;
  logic        step_pend_q;
  logic        dir_x_q;     // 1 = increasing
  logic        dir_y_q;
  logic [9:0]  nx_x_q;
  logic [9:0]  nx_y_q;
  logic        bnc_x_q;
  logic        bnc_y_q;
  logic        frame_end;
  logic        update_go;
  logic [10:0] res_x;
  logic [10:0] res_y;

  // Returns {bounce, new_pos}; 11-bit math so pos+STEP can never wrap.
  function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic inc,
                                            input logic [10:0] max);
    logic [10:0] p;
    logic [10:0] nxt;
    logic [10:0] r;
    p   = {1'b0, pos};
    nxt = p + StepW;
    if (inc) begin
      if (nxt >= max) r = {1'b1, max[9:0]};
      else            r = {1'b0, nxt[9:0]};
    end else begin
      if (p <= StepW) r = 11'h400;
      else            r = {1'b0, pos - StepW[9:0]};
    end
    return r;
  endfunction

  assign frame_end = valid_q & ~valid & (v_cnt == LastLine);
  assign update_go = frame_end & ((run & (frame_div_q == speed)) | (~run & step_pend_q));
  assign res_x     = axis_next(spr_x, dir_x_q, XMax);
  assign res_y     = axis_next(spr_y, dir_y_q, YMax);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= StWait;
      valid_q     <= 1'b0;
      frame_div_q <= 4'd0;
      step_pend_q <= 1'b0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b0;
      nx_x_q      <= 10'(X0);
      nx_y_q      <= 10'(Y0);
      bnc_x_q     <= 1'b0;
      bnc_y_q     <= 1'b0;
      spr_x       <= 10'(X0);
      spr_y       <= 10'(Y0);
      bounce_x    <= 1'b0;
      bounce_y    <= 1'b0;
    end else begin
      valid_q  <= valid;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (frame_end) begin
        if (!run || frame_div_q == speed) frame_div_q <= 4'd0;
        else                              frame_div_q <= frame_div_q + 4'd1;
      end
      case (state_q)
        StWait: begin
          if (update_go) state_q <= StCalcX;
        end
        StCalcX: begin
          bnc_x_q <= res_x[10];
          nx_x_q  <= res_x[9:0];
          state_q <= StCalcY;
        end
        StCalcY: begin
          bnc_y_q <= res_y[10];
          nx_y_q  <= res_y[9:0];
          state_q <= StCommit;
        end
        StCommit: begin
          spr_x       <= nx_x_q;
          spr_y       <= nx_y_q;
          dir_x_q     <= dir_x_q ^ bnc_x_q;
          dir_y_q     <= dir_y_q ^ bnc_y_q;
          bounce_x    <= bnc_x_q;
          bounce_y    <= bnc_y_q;
          step_pend_q <= 1'b0;
          state_q     <= StWait;
        end
        default: state_q <= StWait;
      endcase
      // A step landing on the commit cycle arms the next update rather than being lost.
      if (step && !run) step_pend_q <= 1'b1;
    end
  end

  logic [10:0] h11;
  logic [10:0] v11;
  logic [9:0]  rel_x;
  logic [9:0]  rel_y;
  logic        hit;
  logic [13:0] addr_calc;

  always_comb begin
    h11       = {1'b0, h_cnt};
    v11       = {1'b0, v_cnt};
    rel_x     = h_cnt - spr_x;
    rel_y     = v_cnt - spr_y;
    hit       = valid &
                (h11 >= {1'b0, spr_x}) & (h11 < ({1'b0, spr_x} + SprW11)) &
                (v11 >= {1'b0, spr_y}) & (v11 < ({1'b0, spr_y} + SprH11));
    addr_calc = 14'(rel_y) * 14'(SPR_W) + 14'(rel_x);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      in_sprite <= 1'b0;
      rom_addr  <= 14'd0;
    end else begin
      in_sprite <= hit;
      if (hit) rom_addr <= addr_calc;
    end
  end

endmodule
